mux2_arbiter: RTL and testbench

- Shares one 2:1 sample-path multiplexer between two requesters, for example two demodulator/ADC sample sources competing for one downstream capture path.
- Decides ownership, drives the mux select, and inserts a settle interval after every select change so downstream logic never sees a mid-switch sample.
- Sits between the requesters and the shared 2-bit-select mux instance.
- Provides round-robin fairness with an optional hold limit (preemption).

---
 rtl/mux2_arbiter_pkg.sv | 30 +++
 rtl/mux2_settle_timer.sv | 36 +++
 rtl/mux2_arbiter.sv | 133 +++++++++++++
 tb/tb_mux2_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mux2_arbiter_pkg.sv
// rtl/mux2_arbiter_pkg.sv - shared types and select mapping for the 2:1 sample-path arbiter
// Contents:
//   arb_state_t  : arbiter FSM state encoding
//   SEL_X0/SEL_X1: mux select codes routing requester 0 / requester 1
//   owner_sel    : owner index -> mux select code
//   owner_grant  : owner index -> one-hot grant vector
package mux2_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_OWN    = 2'd2
   } arb_state_t;

   // The shared mux is wired so that 2'b01 selects x0 and 2'b00 selects x1;
   // sel[1] is never used and always stays 0.
   localparam logic [1:0] SEL_X0 = 2'b01;
   localparam logic [1:0] SEL_X1 = 2'b00;

   localparam logic [1:0] GRANT_NONE = 2'b00;

   function automatic logic [1:0] owner_sel(input logic own);
      return own ? SEL_X1 : SEL_X0;
   endfunction

   function automatic logic [1:0] owner_grant(input logic own);
      return own ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mux2_settle_timer.sv
// rtl/mux2_settle_timer.sv - load/decrement countdown used for the mux settle interval
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val this cycle (wins over decrement)
//   load_val : value loaded into the counter
//   done     : count has reached zero
module mux2_settle_timer
   import mux2_arbiter_pkg::*;
#(
   parameter int SETTLE_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [SETTLE_W-1:0] load_val,
   output logic                done
);

   logic [SETTLE_W-1:0] count;

   // Free-runs down to zero and parks there; the arbiter only looks at done
   // while it is in the settle state, right after a load.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - round-robin owner of a shared 2:1 sample mux with settle and optional hold limit
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   req[1:0]   : level requests, bit i = requester i wants the path
//   grant[1:0] : one-hot or zero, requester owns a settled path
//   sel[1:0]   : shared mux select (01 routes requester 0, 00 routes requester 1)
//   path_valid : high exactly when grant is non-zero
//   owner      : requester currently routed by sel
module mux2_arbiter
   import mux2_arbiter_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int SETTLE_W      = 4,
   parameter int HOLD_CYCLES   = 0,
   parameter int HOLD_W        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic [1:0] sel,
   output logic       path_valid,
   output logic       owner
);

   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam bit                  PREEMPT_EN  = (HOLD_CYCLES != 0);
   localparam logic [HOLD_W-1:0]   HOLD_LIMIT  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0]   HOLD_MAX    = {HOLD_W{1'b1}};

   arb_state_t        state, state_n;
   logic [1:0]        grant_n, sel_n;
   logic              owner_n, path_valid_n;
   logic              last_owner, last_owner_n;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
   logic              timer_load, timer_done;
   logic              winner, other;
   logic              release_now;

   mux2_settle_timer #(
      .SETTLE_W (SETTLE_W)
   ) u_settle (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (SETTLE_LOAD),
      .done     (timer_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         grant      <= GRANT_NONE;
         sel        <= SEL_X0;
         owner      <= 1'b0;
         path_valid <= 1'b0;
         last_owner <= 1'b1;   // requester 0 wins the first tie
         hold_cnt   <= '0;
      end else begin
         state      <= state_n;
         grant      <= grant_n;
         sel        <= sel_n;
         owner      <= owner_n;
         path_valid <= path_valid_n;
         last_owner <= last_owner_n;
         hold_cnt   <= hold_cnt_n;
      end
   end

   always_comb begin
      state_n      = state;
      grant_n      = GRANT_NONE;
      sel_n        = sel;
      owner_n      = owner;
      last_owner_n = last_owner;
      hold_cnt_n   = '0;
      timer_load   = 1'b0;
      other        = ~owner;
      winner       = (req == 2'b11) ? ~last_owner : req[1];
      release_now  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (req != 2'b00) begin
               if (winner == owner) begin
                  // Mux already points at the winner: no settle needed.
                  state_n = ST_OWN;
                  grant_n = owner_grant(winner);
               end else begin
                  // The only place sel ever moves; grant is already low here.
                  state_n    = ST_SETTLE;
                  sel_n      = owner_sel(winner);
                  owner_n    = winner;
                  timer_load = 1'b1;
               end
            end
         end

         ST_SETTLE: begin
            if (!req[owner]) begin
               state_n = ST_IDLE;
            end else if (timer_done) begin
               state_n = ST_OWN;
               grant_n = owner_grant(owner);
            end
         end

         ST_OWN: begin
            release_now = !req[owner] ||
                          (PREEMPT_EN && req[other] && (hold_cnt == HOLD_LIMIT));
            if (release_now) begin
               // Dropping to IDLE with last_owner updated lets round-robin
               // hand the path over through a full settle interval.
               state_n      = ST_IDLE;
               last_owner_n = owner;
            end else begin
               grant_n = owner_grant(owner);
               if (req[other]) begin
                  hold_cnt_n = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
               end
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase

      path_valid_n = (grant_n != GRANT_NONE);
   end

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - scoreboard bench for mux2_arbiter across three parameter sets
module tb_mux2_arbiter;

   typedef struct packed {
      logic [1:0] grant;
      logic [1:0] sel;
      logic       owner;
      logic       pv;
   } obs_t;

   typedef struct packed {
      obs_t o0;
      obs_t o1;
      obs_t o2;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [1:0] req;

   logic [1:0] grant_a, sel_a, grant_b, sel_b, grant_c, sel_c;
   logic       pv_a, owner_a, pv_b, owner_b, pv_c, owner_c;

   int errors = 0;
   int checks = 0;

   exp_t exp_q[$];

   // Reference state per instance: who is routed, who went last, whether the
   // path is granted, settle edges still to wait (0 = not settling), hold run.
   int m_owner   [3];
   int m_last    [3];
   int m_granted [3];
   int m_left    [3];
   int m_hold    [3];
   int s_p       [3] = '{4, 4, 1};
   int h_p       [3] = '{0, 8, 1};

   mux2_arbiter #(.SETTLE_CYCLES(4), .SETTLE_W(4), .HOLD_CYCLES(0), .HOLD_W(8)) dut_a (
      .clk(clk), .rst(rst), .req(req), .grant(grant_a), .sel(sel_a),
      .path_valid(pv_a), .owner(owner_a));

   mux2_arbiter #(.SETTLE_CYCLES(4), .SETTLE_W(4), .HOLD_CYCLES(8), .HOLD_W(8)) dut_b (
      .clk(clk), .rst(rst), .req(req), .grant(grant_b), .sel(sel_b),
      .path_valid(pv_b), .owner(owner_b));

   mux2_arbiter #(.SETTLE_CYCLES(1), .SETTLE_W(4), .HOLD_CYCLES(1), .HOLD_W(8)) dut_c (
      .clk(clk), .rst(rst), .req(req), .grant(grant_c), .sel(sel_c),
      .path_valid(pv_c), .owner(owner_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_step(input int i, input bit r, input logic [1:0] q);
      int oth;
      int w;
      oth = 1 - m_owner[i];
      if (r) begin
         m_owner[i]   = 0;
         m_last[i]    = 1;
         m_granted[i] = 0;
         m_left[i]    = 0;
         m_hold[i]    = 0;
      end else if (m_granted[i] != 0) begin
         if (!q[m_owner[i]] || (h_p[i] > 0 && q[oth] && m_hold[i] == h_p[i] - 1)) begin
            m_granted[i] = 0;
            m_last[i]    = m_owner[i];
            m_hold[i]    = 0;
         end else begin
            m_hold[i] = q[oth] ? ((m_hold[i] < 255) ? m_hold[i] + 1 : 255) : 0;
         end
      end else if (m_left[i] > 0) begin
         if (!q[m_owner[i]]) begin
            m_left[i] = 0;
         end else if (m_left[i] == 1) begin
            m_left[i]    = 0;
            m_granted[i] = 1;
            m_hold[i]    = 0;
         end else begin
            m_left[i] = m_left[i] - 1;
         end
      end else if (q != 2'b00) begin
         w = (q == 2'b11) ? 1 - m_last[i] : (q[1] ? 1 : 0);
         if (w == m_owner[i]) begin
            m_granted[i] = 1;
            m_hold[i]    = 0;
         end else begin
            m_owner[i] = w;
            m_left[i]  = s_p[i];
         end
      end
   endtask

   function automatic obs_t model_obs(input int i);
      obs_t o;
      o.owner = (m_owner[i] == 1);
      o.sel   = (m_owner[i] == 1) ? 2'b00 : 2'b01;
      o.grant = (m_granted[i] == 0) ? 2'b00 : ((m_owner[i] == 1) ? 2'b10 : 2'b01);
      o.pv    = (m_granted[i] != 0);
      return o;
   endfunction

   task automatic drive(input bit r, input logic [1:0] q, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst = r;
         req = q;
         for (int i = 0; i < 3; i++) model_step(i, r, q);
         e.o0 = model_obs(0);
         e.o1 = model_obs(1);
         e.o2 = model_obs(2);
         exp_q.push_back(e);
      end
   endtask

   task automatic check(input string name, input obs_t exp, input obs_t act);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got grant=%b sel=%b owner=%b pv=%b want grant=%b sel=%b owner=%b pv=%b",
                  name, $time, act.grant, act.sel, act.owner, act.pv,
                  exp.grant, exp.sel, exp.owner, exp.pv);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("dut_a", e.o0, {grant_a, sel_a, owner_a, pv_a});
            check("dut_b", e.o1, {grant_b, sel_b, owner_b, pv_b});
            check("dut_c", e.o2, {grant_c, sel_c, owner_c, pv_c});
         end
      end
   end

   initial begin : stimulus
      logic [1:0] q;
      int         n;
      bit         r;
      rst = 1'b1;
      req = 2'b00;
      for (int i = 0; i < 3; i++) model_step(i, 1'b1, 2'b00);

      // Owner already 0: grant one cycle after request.
      drive(1, 2'b00, 2);
      drive(0, 2'b01, 4);
      // Requester 1 alone: sel flips, grant after settle.
      drive(1, 2'b00, 1);
      drive(0, 2'b10, 8);
      // Tie from reset, release to other side, re-request without preemption.
      drive(1, 2'b00, 1);
      drive(0, 2'b11, 4);
      drive(0, 2'b10, 7);
      drive(0, 2'b11, 12);
      // Long contention: hold limit forces handover on the limited instances.
      drive(1, 2'b00, 1);
      drive(0, 2'b11, 40);
      // Request drops during settle, then requester 0 re-settles.
      drive(1, 2'b00, 1);
      drive(0, 2'b10, 2);
      drive(0, 2'b00, 3);
      drive(0, 2'b01, 8);
      // Reset mid-grant and mid-settle with both still requesting.
      drive(0, 2'b11, 3);
      drive(1, 2'b11, 1);
      drive(0, 2'b11, 3);
      drive(0, 2'b10, 2);
      drive(1, 2'b11, 1);
      drive(0, 2'b11, 6);

      repeat (200) begin
         q = 2'($urandom_range(0, 3));
         n = $urandom_range(1, 14);
         r = ($urandom_range(0, 40) == 0);
         drive(r, q, r ? 1 : n);
      end

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
